cp0_int_unit: RTL and testbench

- Coprocessor-0 interrupt/exception receiver for the P7 MIPS core: the consuming end of the device IRQ lines driven by the timers and other bus responders.
- Latches hardware interrupt lines and holds SR/Cause/EPC/PRId.
- Decides each cycle whether the macro-instruction in the M stage is to be preempted, and supplies the handler return address for eret.
- Sits beside the M stage; mfc0/mtc0 access it through a 5-bit register index.

---
 rtl/cp0_int_unit_pkg.sv | 33 +++
 rtl/cp0_int_unit.sv | 107 ++++++++++
 tb/tb_cp0_int_unit.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/cp0_int_unit_pkg.sv
// Shared CP0 constants: register indices, field positions, exception codes, mode encoding.
package cp0_int_unit_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned IRQ_W    = 6;
  localparam int unsigned EXC_W    = 5;

  localparam logic [ADDR_W-1:0] REG_SR    = 5'd12;
  localparam logic [ADDR_W-1:0] REG_CAUSE = 5'd13;
  localparam logic [ADDR_W-1:0] REG_EPC   = 5'd14;
  localparam logic [ADDR_W-1:0] REG_PRID  = 5'd15;

  localparam int unsigned SR_IE     = 0;
  localparam int unsigned SR_EXL    = 1;
  localparam int unsigned SR_IM_LO  = 10;
  localparam int unsigned SR_IM_HI  = 15;

  localparam logic [EXC_W-1:0] EXC_INT  = 5'd0;
  localparam logic [EXC_W-1:0] EXC_ADEL = 5'd4;
  localparam logic [EXC_W-1:0] EXC_ADES = 5'd5;
  localparam logic [EXC_W-1:0] EXC_RI   = 5'd10;
  localparam logic [EXC_W-1:0] EXC_OV   = 5'd12;

  localparam logic [DATA_W-1:0] HANDLER_ADDR = 32'h0000_4180;

  // EXL expressed as the unit's operating mode.
  typedef enum logic {
    MODE_NORMAL  = 1'b0,
    MODE_HANDLER = 1'b1
  } cp0_mode_e;

endpackage

// File: rtl/cp0_int_unit.sv
// CP0 interrupt/exception receiver: SR/Cause/EPC/PRId, request decision, eret return address.
module cp0_int_unit
  import cp0_int_unit_pkg::*;
#(
  parameter logic [31:0] PRID = 32'h0000_2021
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  Addr,
  input  logic        WE,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  input  logic [31:0] PC,
  input  logic        BD,
  input  logic [4:0]  ExcCode,
  input  logic [5:0]  HWInt,
  input  logic        EXLClr,
  output logic        Req,
  output logic [31:0] EPCOut
);

  cp0_mode_e          mode_q, mode_d;
  logic [IRQ_W-1:0]   im_q, im_d;
  logic               ie_q, ie_d;
  logic [IRQ_W-1:0]   ip_q;
  logic               bd_q, bd_d;
  logic [EXC_W-1:0]   exc_q, exc_d;
  logic [DATA_W-1:0]  epc_q, epc_d;

  logic               int_req, exc_req;
  logic               wr_sr, wr_epc;
  logic [DATA_W-1:0]  pc_aligned;

  // Request decision from current SR and live device lines.
  always_comb begin
    int_req = (|(HWInt & im_q)) & ie_q & (mode_q == MODE_NORMAL);
    exc_req = (ExcCode != '0) & (mode_q == MODE_NORMAL);
    Req     = int_req | exc_req;
  end

  // Next-state: exception entry beats eret, which beats a same-cycle mtc0.
  always_comb begin
    mode_d     = mode_q;
    im_d       = im_q;
    ie_d       = ie_q;
    bd_d       = bd_q;
    exc_d      = exc_q;
    epc_d      = epc_q;
    pc_aligned = {PC[31:2], 2'b00};
    wr_sr      = WE && (Addr == REG_SR)  && !Req && !EXLClr;
    wr_epc     = WE && (Addr == REG_EPC) && !Req;

    if (Req) begin
      mode_d = MODE_HANDLER;
      bd_d   = BD;
      exc_d  = int_req ? EXC_INT : ExcCode;
      epc_d  = BD ? DATA_W'(pc_aligned - 32'd4) : pc_aligned;
    end else begin
      if (EXLClr) begin
        mode_d = MODE_NORMAL;
      end else if (wr_sr) begin
        mode_d = Din[SR_EXL] ? MODE_HANDLER : MODE_NORMAL;
        im_d   = Din[SR_IM_HI:SR_IM_LO];
        ie_d   = Din[SR_IE];
      end
      if (wr_epc) begin
        epc_d = Din;
      end
    end
  end

  // Register update with synchronous reset; IP samples HWInt every cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q <= MODE_NORMAL;
      im_q   <= '0;
      ie_q   <= 1'b0;
      ip_q   <= '0;
      bd_q   <= 1'b0;
      exc_q  <= '0;
      epc_q  <= '0;
    end else begin
      mode_q <= mode_d;
      im_q   <= im_d;
      ie_q   <= ie_d;
      ip_q   <= HWInt;
      bd_q   <= bd_d;
      exc_q  <= exc_d;
      epc_q  <= epc_d;
    end
  end

  // mfc0 read mux; reflects register contents before the current edge.
  always_comb begin
    Dout = '0;
    unique case (Addr)
      REG_SR:    Dout = {16'b0, im_q, 8'b0, (mode_q == MODE_HANDLER), ie_q};
      REG_CAUSE: Dout = {bd_q, 15'b0, ip_q, 3'b0, exc_q, 2'b00};
      REG_EPC:   Dout = epc_q;
      REG_PRID:  Dout = PRID;
      default:   Dout = '0;
    endcase
  end

  assign EPCOut = epc_q;

endmodule

// File: tb/tb_cp0_int_unit.sv
// Directed self-checking bench for cp0_int_unit.
module tb_cp0_int_unit;

  logic        clk;
  logic        reset;
  logic [4:0]  Addr;
  logic        WE;
  logic [31:0] Din;
  logic [31:0] Dout;
  logic [31:0] PC;
  logic        BD;
  logic [4:0]  ExcCode;
  logic [5:0]  HWInt;
  logic        EXLClr;
  logic        Req;
  logic [31:0] EPCOut;

  int checks = 0;
  int passed = 0;

  cp0_int_unit dut (
    .clk     (clk),
    .reset   (reset),
    .Addr    (Addr),
    .WE      (WE),
    .Din     (Din),
    .Dout    (Dout),
    .PC      (PC),
    .BD      (BD),
    .ExcCode (ExcCode),
    .HWInt   (HWInt),
    .EXLClr  (EXLClr),
    .Req     (Req),
    .EPCOut  (EPCOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [4:0] a, input logic [31:0] exp, input string tag);
    Addr = a;
    #1;
    chk(tag, Dout, exp);
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    Addr = a; Din = d; WE = 1'b1;
    tick();
    WE = 1'b0;
  endtask

  initial begin
    reset = 1'b1; Addr = '0; WE = 1'b0; Din = '0; PC = '0; BD = 1'b0;
    ExcCode = '0; HWInt = '0; EXLClr = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    rd(5'd12, 32'h0, "rst_sr");
    rd(5'd13, 32'h0, "rst_cause");
    rd(5'd14, 32'h0, "rst_epc");
    chk("rst_epcout", EPCOut, 32'h0);
    chk("rst_req", {31'b0, Req}, 32'h0);
    rd(5'd15, 32'h0000_2021, "prid");
    rd(5'd3, 32'h0, "other_idx");

    // 1: writable SR fields only; Cause is read-only
    mtc0(5'd12, 32'hFFFF_FFFF);
    rd(5'd12, 32'h0000_FC03, "sr_mask");
    mtc0(5'd13, 32'hFFFF_FFFF);
    rd(5'd13, 32'h0, "cause_ro");
    mtc0(5'd15, 32'h1234_5678);
    rd(5'd15, 32'h0000_2021, "prid_ro");

    // 2: timer interrupt entry
    mtc0(5'd12, 32'h0000_0401);
    HWInt = 6'b000001; PC = 32'h0000_3010; BD = 1'b0;
    #1;
    chk("t2_req", {31'b0, Req}, 32'h1);
    tick();
    HWInt = 6'b0;
    #1;
    chk("t2_epc", EPCOut, 32'h0000_3010);
    rd(5'd13, 32'h0000_0400, "t2_cause");
    rd(5'd12, 32'h0000_0403, "t2_sr");
    chk("t2_req_after", {31'b0, Req}, 32'h0);

    // 3: overflow exception in a delay slot
    mtc0(5'd12, 32'h0000_0001);
    ExcCode = 5'd12; BD = 1'b1; PC = 32'h0000_3024;
    #1;
    chk("t3_req", {31'b0, Req}, 32'h1);
    tick();
    ExcCode = 5'd0; BD = 1'b0;
    #1;
    chk("t3_epc", EPCOut, 32'h0000_3020);
    rd(5'd13, 32'h8000_0030, "t3_cause");

    // 4: no nested entry in handler; level IRQ fires once EXL clears
    mtc0(5'd12, 32'h0000_0403);
    HWInt = 6'b000001; ExcCode = 5'd10;
    #1;
    chk("t4_req_hold_a", {31'b0, Req}, 32'h0);
    tick();
    ExcCode = 5'd0;
    #1;
    chk("t4_req_hold_b", {31'b0, Req}, 32'h0);
    EXLClr = 1'b1;
    #1;
    chk("t4_req_eret_cyc", {31'b0, Req}, 32'h0);
    tick();
    EXLClr = 1'b0;
    rd(5'd12, 32'h0000_0401, "t4_sr_exl_clr");
    chk("t4_req_after_eret", {31'b0, Req}, 32'h1);

    // 5: mtc0 EPC dropped in the entry cycle
    PC = 32'h0000_3040; BD = 1'b0;
    Addr = 5'd14; Din = 32'hDEAD_BEEF; WE = 1'b1;
    tick();
    WE = 1'b0; HWInt = 6'b0;
    #1;
    chk("t5_epc", EPCOut, 32'h0000_3040);
    rd(5'd13, 32'h0000_0400, "t5_cause");

    // 6: reset from handler with programmed EPC
    mtc0(5'd14, 32'h0000_3100);
    chk("t6_epc_wr", EPCOut, 32'h0000_3100);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    rd(5'd12, 32'h0, "t6_sr");
    rd(5'd13, 32'h0, "t6_cause");
    rd(5'd14, 32'h0, "t6_epc");
    chk("t6_req", {31'b0, Req}, 32'h0);

    // EPC wrap: delay slot at PC 0 (unaligned low bits ignored)
    mtc0(5'd12, 32'h0000_0001);
    ExcCode = 5'd4; BD = 1'b1; PC = 32'h0000_0002;
    #1;
    chk("wrap_req", {31'b0, Req}, 32'h1);
    tick();
    ExcCode = 5'd0; BD = 1'b0;
    #1;
    chk("wrap_epc", EPCOut, 32'hFFFF_FFFC);
    rd(5'd13, 32'h8000_0010, "wrap_cause");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
